// File: rtl/pipeline_requester_pkg.sv
// pipeline_requester_pkg: requester FSM states and default data width,
// shared with the global-stall resource side.
package pipeline_requester_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RES,
        FLUSH
    } req_state_e;

endpackage

// File: rtl/pipeline_requester_starve_cnt.sv
// requester_starve_cnt: saturating count of cycles a request waited
// without acceptance; built only when STARVE_CNT_EN is defined.
`ifdef STARVE_CNT_EN
module requester_starve_cnt #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign starve = (cnt_q == CNT_MAX);

endmodule
`endif

// File: rtl/pipeline_requester.sv
// pipeline_requester: per-pipeline requester for the global-stall resource.
// Optional starvation counter enabled by defining STARVE_CNT_EN.
module pipeline_requester
    import pipeline_requester_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
`ifdef STARVE_CNT_EN
   ,parameter int unsigned STARVE_LIMIT = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    input  logic              flush_req,
    output logic              req_valid,
    output logic [DATA_W-1:0] req_data,
    output logic              req_flush,
    input  logic              res_grant,
    input  logic              res_stall,
    input  logic              res_out_valid,
    input  logic              res_out_flush,
    input  logic [DATA_W-1:0] res_out_data,
    output logic              dn_valid,
    output logic [DATA_W-1:0] dn_data,
    output logic              flush_done,
    output logic              starve
);

    req_state_e        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] dn_data_d;
    logic              flush_sent_q, flush_sent_d;
    logic              dn_valid_d;
    logic              err_q, err_d;
    logic              accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            flush_sent_q <= 1'b0;
            dn_valid     <= 1'b0;
            dn_data      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            flush_sent_q <= flush_sent_d;
            dn_valid     <= dn_valid_d;
            dn_data      <= dn_data_d;
            err_q        <= err_d;
        end
    end

    assign req_data = hold_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        flush_sent_d = flush_sent_q;
        dn_valid_d   = 1'b0;
        dn_data_d    = dn_data;
        err_d        = err_q;
        up_ready     = 1'b0;
        req_valid    = 1'b0;
        req_flush    = 1'b0;
        flush_done   = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            IDLE: begin
                up_ready = !flush_req && !reset;
                if (up_valid && !flush_req) begin
                    hold_d  = up_data;
                    state_d = REQ;
                end
            end
            REQ: begin
                req_valid = !flush_req;
                accept    = res_grant && !res_stall && !flush_req;
                if (accept) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                state_d = IDLE;
                if (!flush_req) begin
                    if (res_out_valid) begin
                        dn_valid_d = 1'b1;
                        dn_data_d  = res_out_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Once sent, the resource confirms one cycle later or we resend.
                if (!flush_sent_q) begin
                    req_flush = 1'b1;
                    if (!res_stall) begin
                        flush_sent_d = 1'b1;
                    end
                end else begin
                    flush_sent_d = 1'b0;
                    if (res_out_flush) begin
                        flush_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
        endcase

        if (flush_req && (state_q != FLUSH)) begin
            state_d      = FLUSH;
            hold_d       = '0;
            flush_sent_d = 1'b0;
        end
    end

`ifdef STARVE_CNT_EN
    logic starve_inc;

    assign starve_inc = (state_q == REQ) && !accept && !flush_req;

    requester_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (starve_inc),
        .clr    (!starve_inc),
        .starve (starve)
    );
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_requester.sv
// tb_pipeline_requester: directed and random stimulus for pipeline_requester
// checked every cycle against a transaction-level model with a resource stub.
module tb_pipeline_requester;

    localparam int DW    = 32;
    localparam int LIMIT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic          up_ready;
    logic          flush_req;
    logic          req_valid;
    logic [DW-1:0] req_data;
    logic          req_flush;
    logic          res_grant;
    logic          res_stall;
    logic          res_out_valid;
    logic          res_out_flush;
    logic [DW-1:0] res_out_data;
    logic          dn_valid;
    logic [DW-1:0] dn_data;
    logic          flush_done;
    logic          starve;

    always #5 clk = ~clk;

    pipeline_requester dut (
        .clk           (clk),
        .reset         (reset),
        .up_valid      (up_valid),
        .up_data       (up_data),
        .up_ready      (up_ready),
        .flush_req     (flush_req),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_flush     (req_flush),
        .res_grant     (res_grant),
        .res_stall     (res_stall),
        .res_out_valid (res_out_valid),
        .res_out_flush (res_out_flush),
        .res_out_data  (res_out_data),
        .dn_valid      (dn_valid),
        .dn_data       (dn_data),
        .flush_done    (flush_done),
        .starve        (starve)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // model: op held, accepted last cycle, flushing, flush sent to resource
    bit          m_busy, m_acc, m_flushing, m_sent, m_dn_v, m_err;
    logic [DW-1:0] m_hold, m_dn_d;
    int          m_wait;

    logic          s_reset, s_uv, s_fr, s_gr, s_st, s_ov, s_of;
    logic          s_rv, s_rf;
    logic [DW-1:0] s_ud, s_od, s_rd;
    bit            drop_en = 1'b0;

    task automatic model_init();
        m_busy = 0; m_acc = 0; m_flushing = 0; m_sent = 0;
        m_dn_v = 0; m_err = 0; m_hold = '0; m_dn_d = '0; m_wait = 0;
    endtask

    function automatic bit exp_starve(input int waited);
`ifdef STARVE_CNT_EN
        return waited >= LIMIT;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        chk("up_ready", 32'(up_ready),
            32'(!m_busy && !m_acc && !m_flushing && !flush_req && !reset));
        chk("req_valid", 32'(req_valid), 32'(m_busy && !flush_req));
        chk("req_data", req_data, m_hold);
        chk("req_flush", 32'(req_flush), 32'(m_flushing && !m_sent));
        chk("flush_done", 32'(flush_done),
            32'(m_flushing && m_sent && res_out_flush));
        chk("dn_valid", 32'(dn_valid), 32'(m_dn_v));
        chk("dn_data", dn_data, m_dn_d);
        chk("starve", 32'(starve), 32'(exp_starve(m_wait)));
        chk("err_q", 32'(dut.err_q), 32'(m_err));
    endtask

    task automatic model_update();
        bit acc;
        if (s_reset) begin
            model_init();
            return;
        end
        acc    = m_busy && s_gr && !s_st && !s_fr;
        m_dn_v = 0;
        if (m_acc && !s_fr) begin
            if (s_ov) begin
                m_dn_v = 1;
                m_dn_d = s_od;
            end else begin
                m_err = 1;
            end
        end
        if (s_fr && !m_flushing) begin
            m_busy = 0; m_acc = 0; m_hold = '0;
            m_flushing = 1; m_sent = 0; m_wait = 0;
        end else if (m_flushing) begin
            if (!m_sent) begin
                m_sent = !s_st;
            end else begin
                if (s_of) m_flushing = 0;
                m_sent = 0;
            end
        end else if (m_acc) begin
            m_acc = 0;
        end else if (m_busy) begin
            if (acc) begin
                m_busy = 0; m_acc = 1; m_wait = 0;
            end else if (m_wait < LIMIT) begin
                m_wait++;
            end
        end else if (s_uv) begin
            m_busy = 1; m_hold = s_ud; m_wait = 0;
        end
    endtask

    // resource stub: registered result one cycle after it latches a request
    task automatic res_update();
        bit take;
        if (s_reset) begin
            res_out_valid = 0; res_out_flush = 0; res_out_data = '0;
            return;
        end
        take = s_rv && s_gr && !s_st;
        res_out_valid = take && !(drop_en && $urandom_range(0, 15) == 0);
        res_out_data  = take ? s_rd : DW'($urandom);
        res_out_flush = s_rf && !s_st && !(drop_en && $urandom_range(0, 3) == 0);
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        s_reset = reset; s_uv = up_valid; s_ud = up_data; s_fr = flush_req;
        s_gr = res_grant; s_st = res_stall; s_ov = res_out_valid;
        s_od = res_out_data; s_of = res_out_flush;
        s_rv = req_valid; s_rd = req_data; s_rf = req_flush;
        @(posedge clk);
        #1;
        model_update();
        res_update();
        #1;
    endtask

    task automatic set_in(input logic uv, input logic [DW-1:0] ud,
                          input logic fr, input logic gr, input logic st);
        up_valid = uv; up_data = ud; flush_req = fr;
        res_grant = gr; res_stall = st;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_init();
        res_out_valid = 0; res_out_flush = 0; res_out_data = '0;
        #1;
        check_outputs();
    endtask

    initial begin
        set_in(0, '0, 0, 0, 0);
        apply_reset();
        step();
        reset = 1'b0;

        // single op, immediate grant
        set_in(1, 32'hA5A5_0001, 0, 1, 0);
        step();
        set_in(0, '0, 0, 1, 0);
        step();
        step();
        chk("t1_dn_valid", 32'(dn_valid), 32'd1);
        chk("t1_dn_data", dn_data, 32'hA5A5_0001);
        step();
        chk("t1_dn_pulse", 32'(dn_valid), 32'd0);

        // stall hold for 5 cycles
        set_in(1, 32'h1234_5678, 0, 1, 1);
        step();
        set_in(0, '0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_req_valid", 32'(req_valid), 32'd1);
            chk("t2_req_data", req_data, 32'h1234_5678);
        end
        res_stall = 0;
        step();
        chk("t2_no_early_dn", 32'(dn_valid), 32'd0);
        step();
        chk("t2_dn_data", dn_data, 32'h1234_5678);
        chk("t2_dn_valid", 32'(dn_valid), 32'd1);
        step();

        // lost arbitration for 20 cycles
        set_in(1, 32'hCAFE_0003, 0, 0, 0);
        step();
        set_in(0, '0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("t3_starve_%0d", k), 32'(starve), 32'(exp_starve(k)));
        end
        res_grant = 1;
        step();
        chk("t3_starve_clr", 32'(starve), 32'd0);
        step();
        chk("t3_dn_data", dn_data, 32'hCAFE_0003);
        step();

        // flush during stall
        set_in(1, 32'hDEAD_0004, 0, 1, 1);
        step();
        set_in(0, '0, 1, 1, 1);
        step();
        flush_req = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_req_flush", 32'(req_flush), 32'd1);
            chk("t4_req_valid", 32'(req_valid), 32'd0);
            step();
        end
        res_stall = 0;
        step();
        chk("t4_flush_done", 32'(flush_done), 32'd1);
        step();
        chk("t4_done_pulse", 32'(flush_done), 32'd0);
        chk("t4_no_dn", 32'(dn_valid), 32'd0);

        // flush beats upstream in IDLE
        set_in(1, 32'hBEEF_0005, 1, 0, 0);
        #1;
        chk("t5_up_ready", 32'(up_ready), 32'd0);
        step();
        chk("t5_req_flush", 32'(req_flush), 32'd1);
        chk("t5_not_latched", req_data, 32'd0);
        set_in(0, '0, 0, 0, 0);
        step();
        chk("t5_flush_done", 32'(flush_done), 32'd1);
        step();

        // reset mid-WAIT_RES, then a fresh op
        set_in(1, 32'h0BAD_0006, 0, 1, 0);
        step();
        set_in(0, '0, 0, 1, 0);
        step();
        apply_reset();
        chk("t6_dn_valid", 32'(dn_valid), 32'd0);
        chk("t6_req_valid", 32'(req_valid), 32'd0);
        step();
        reset = 1'b0;
        step();
        set_in(1, 32'h600D_0007, 0, 1, 0);
        step();
        set_in(0, '0, 0, 1, 0);
        step();
        step();
        chk("t6_fresh_dn", dn_data, 32'h600D_0007);
        chk("t6_fresh_valid", 32'(dn_valid), 32'd1);
        step();

        // random traffic with occasional resource desync and resets
        drop_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            set_in(1'($urandom_range(0, 1)), DW'($urandom),
                   $urandom_range(0, 11) == 0,
                   $urandom_range(0, 9) < 7,
                   $urandom_range(0, 9) < 3);
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
                step();
                reset = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
